// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the 8-bit nRisc core.
//
// Holds the program counter, fetches the instruction at pc from instruction
// memory over a req/ack handshake, keeps it in the instruction register (iReg)
// until the core consumes it, and exports pc+1 to the branch/jump mux chain.
//
// Ports:
//   clock        in   rising-edge system clock
//   reset        in   asynchronous, active-high reset
//   next_pc      in   next PC chosen by MUX5; sampled when advance is accepted
//   advance      in   core has consumed instr; load next_pc and fetch again
//   imem_req     out  fetch request to instruction memory
//   imem_addr    out  fetch address (always pc)
//   imem_ack     in   memory returns data this cycle
//   imem_data    in   instruction word, valid with imem_ack
//   instr        out  instruction register contents
//   instr_valid  out  instr holds the instruction at pc
//   pc           out  current program counter
//   pc_plus1     out  pc + 1 modulo 2^WIDTH (combinational)
//   halted       out  sticky; halt opcode consumed
//   fetch_err    out  sticky; fetch timed out waiting for imem_ack
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [WIDTH-1:0] HALT_OPCODE = '1,
    parameter int              TIMEOUT     = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             advance,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             halted,
    output logic             fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        HALTED,
        ERROR
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;   // consecutive no-ack FETCH cycles; TIMEOUT fits in 8 bits
    logic [7:0] wait_next;

    assign wait_next = wait_cnt + 8'd1;

    // Request is decoded straight from state so an asynchronous reset drops it
    // immediately, without waiting for a clock edge.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign pc_plus1  = pc + WIDTH'(1);

    // NOTE: every register here is sequential state, so all assignments in this
    // block are non-blocking; mixing in blocking writes would make the result
    // depend on statement order and simulate differently from the netlist.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            unique case (state)
                // One idle cycle after reset before the first request.
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    // Ack wins over a timeout reached in the same cycle.
                    if (imem_ack) begin
                        instr       <= imem_data;
                        instr_valid <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= HOLD;
                    end else if (wait_next == 8'(TIMEOUT)) begin
                        wait_cnt  <= wait_next;
                        fetch_err <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end

                HOLD: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        wait_cnt    <= 8'd0;
                        if (instr == HALT_OPCODE) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end
                end

                // Absorbing; only reset leaves these states.
                HALTED, ERROR: begin
                    state <= state;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// A behavioural reference model tracks what the fetch stage should present:
// whether it has started, the current pc, the held instruction, how long the
// current fetch has waited, and the sticky halt/error flags. Directed steps
// follow the test plan, then a randomized phase exercises latency, data,
// jumps and resets.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int         WIDTH   = 8;
    localparam int         TIMEOUT = 15;
    localparam logic [7:0] RST_PC  = 8'h00;
    localparam logic [7:0] HALT_OP = 8'hFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] next_pc = '0;
    logic       advance = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = '0;
    logic [7:0] instr;
    logic       instr_valid;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       halted;
    logic       fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit         m_started;
    bit         m_valid;
    bit         m_halt;
    bit         m_err;
    logic [7:0] m_pc;
    logic [7:0] m_instr;
    int         m_waits;

    fetch_unit #(
        .WIDTH      (WIDTH),
        .RESET_PC   (RST_PC),
        .HALT_OPCODE(HALT_OP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .next_pc    (next_pc),
        .advance    (advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_valid   = 0;
        m_halt    = 0;
        m_err     = 0;
        m_pc      = RST_PC;
        m_instr   = 8'h00;
        m_waits   = 0;
    endtask

    // What one clock edge should do, given the inputs present at that edge.
    task automatic model_edge();
        if (!m_started) begin
            m_started = 1;
        end else if (m_halt || m_err) begin
            // nothing changes until reset
        end else if (m_valid) begin
            if (advance) begin
                m_valid = 0;
                if (m_instr == HALT_OP) m_halt = 1;
                else                    m_pc   = next_pc;
            end
        end else begin
            if (imem_ack) begin
                m_instr = imem_data;
                m_valid = 1;
                m_waits = 0;
            end else begin
                m_waits++;
                if (m_waits == TIMEOUT) m_err = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_req;
        exp_req = m_started && !m_valid && !m_halt && !m_err;
        check({tag, ".req"},   8'(imem_req),    8'(exp_req));
        check({tag, ".addr"},  imem_addr,       m_pc);
        check({tag, ".pc"},    pc,              m_pc);
        check({tag, ".pc1"},   pc_plus1,        m_pc + 8'd1);
        check({tag, ".instr"}, instr,           m_instr);
        check({tag, ".valid"}, 8'(instr_valid), 8'(m_valid));
        check({tag, ".halt"},  8'(halted),      8'(m_halt));
        check({tag, ".err"},   8'(fetch_err),   8'(m_err));
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges, checked before any edge, released mid-cycle.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic drive(input bit adv, input logic [7:0] npc, input bit ack, input logic [7:0] data);
        advance   = adv;
        next_pc   = npc;
        imem_ack  = ack;
        imem_data = data;
    endtask

    initial begin
        model_reset();

        // 1. Reset, then zero-wait memory returning 8'h11.
        drive(0, 8'h00, 1, 8'h11);
        do_reset("rst");
        step("t1.idle");                       // first request in cycle 2
        check("t1.req_rise", 8'(imem_req), 8'h01);
        step("t1.fetch");
        check("t1.instr11", instr, 8'h11);
        check("t1.pc1_01", pc_plus1, 8'h01);

        // 2. Jump to 0D, data arrives after 3 wait cycles.
        drive(1, 8'h0D, 0, 8'h00);
        step("t2.adv");
        check("t2.pc0D", pc, 8'h0D);
        drive(0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 3; i++) step("t2.wait");
        check("t2.addr0D", imem_addr, 8'h0D);
        drive(0, 8'h00, 1, 8'h22);
        step("t2.ack");
        check("t2.instr22", instr, 8'h22);

        // 3. Wrap: pc=FF gives pc_plus1=00; advancing to pc_plus1 fetches 00.
        drive(1, 8'hFF, 0, 8'h00);
        step("t3.jmpFF");
        drive(0, 8'h00, 1, 8'h33);
        step("t3.fetchFF");
        check("t3.pc1wrap", pc_plus1, 8'h00);
        drive(1, m_pc + 8'd1, 0, 8'h00);
        step("t3.adv_wrap");
        check("t3.addr00", imem_addr, 8'h00);

        // 5a. Timeout: no ack for TIMEOUT fetch cycles.
        drive(0, 8'h00, 0, 8'h00);
        for (int i = 0; i < TIMEOUT - 1; i++) step("t5.wait");
        check("t5.no_err_yet", 8'(fetch_err), 8'h00);
        step("t5.timeout");
        check("t5.err", 8'(fetch_err), 8'h01);
        drive(1, 8'h40, 1, 8'h44);
        for (int i = 0; i < 4; i++) step("t5.absorb");

        // 5b. Ack in the 15th fetch cycle wins over the timeout.
        drive(0, 8'h00, 0, 8'h00);
        do_reset("t5b.rst");
        step("t5b.idle");
        for (int i = 0; i < TIMEOUT - 1; i++) step("t5b.wait");
        drive(0, 8'h00, 1, 8'h55);
        step("t5b.late_ack");
        check("t5b.valid", 8'(instr_valid), 8'h01);
        check("t5b.err0", 8'(fetch_err), 8'h00);

        // 4. Halt: fetch FF, consume it, then everything is frozen.
        drive(1, 8'h05, 0, 8'h00);
        step("t4.adv");
        drive(0, 8'h00, 1, HALT_OP);
        step("t4.fetchFF");
        drive(1, 8'h77, 0, 8'h00);
        step("t4.consume");
        check("t4.halted", 8'(halted), 8'h01);
        check("t4.pc05", pc, 8'h05);
        for (int i = 0; i < 22; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
            step("t4.frozen");
        end

        // 6. Reset in the middle of a fetch, between edges.
        drive(0, 8'h00, 0, 8'h00);
        do_reset("t6.rst0");
        step("t6.idle");
        step("t6.wait");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("t6.req_drop", 8'(imem_req), 8'h00);
        check("t6.pc_rst", pc, RST_PC);
        @(posedge clock);
        #2;
        reset = 1'b0;
        step("t6.restart");
        check("t6.req_again", 8'(imem_req), 8'h01);

        // Randomized phase: variable latency, random jumps, occasional halts,
        // periodic resets so absorbing states do not stall coverage.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (d == HALT_OP && $urandom_range(0, 3) != 0) d = 8'h5A;
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0), d);
            if (i % 60 == 59) do_reset("rnd.rst");
            else              step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
